// File: rtl/timing_pattern_gen.sv
// Video timing generator with selectable test patterns.
// Free-running cx/cy counters describe the pixel being prepared; every output
// is registered, so the outputs always show the previous cycle's counter state.
// Pattern select and frame counter update at pixel (0,0) and take effect on
// that same pixel.
module timing_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 8,
    parameter int XW       = 11,
    parameter int YW       = 11
) (
    input  logic          pixclk,
    input  logic          rst,
    input  logic [2:0]    mode,
    output logic          draw_area,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [7:0]    frame_cnt,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT      = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_EDGE     = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] X_HS_ON    = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_HS_OFF   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] X_BAR_LAST = XW'(BAR_W - 1);

    localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT      = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_EDGE     = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] Y_VS_ON    = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_VS_OFF   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] Y_BOX_TOP  = YW'(V_ACTIVE / 2 - 16);
    localparam logic [YW-1:0] Y_BOX_BOT  = YW'(V_ACTIVE / 2 + 16);

    localparam logic [XW:0]   BX_WRAP    = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0]   BX_STEP    = (XW+1)'(2);
    localparam logic [XW:0]   BOX_SIZE   = (XW+1)'(32);
    localparam logic [CW-1:0] FULL       = {CW{1'b1}};

    // Raster position of the pixel being prepared this cycle
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    // Colour-bar index and position inside the current bar (tracks cx)
    logic [2:0]    bar_i;
    logic [XW-1:0] bar_cnt;
    // Per-frame state
    logic [2:0]    mode_q;
    logic [XW-1:0] box_x;

    logic          at_start;
    logic [7:0]    fc_next;
    logic [XW:0]   bx_sum;
    logic [XW-1:0] bx_next;
    logic [2:0]    mode_e;
    logic [XW-1:0] bx_e;
    logic [XW:0]   cx_w;
    logic [XW:0]   bx_w;
    logic          in_box;
    logic          draw_c;
    logic          hs_c;
    logic          vs_c;
    logic [CW+7:0] ramp_w;
    logic [CW-1:0] r_c;
    logic [CW-1:0] g_c;
    logic [CW-1:0] b_c;

    // Raster counters plus the bar tracker that replaces a divide by BAR_W
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            cx      <= '0;
            cy      <= '0;
            bar_i   <= '0;
            bar_cnt <= '0;
        end else if (cx == X_LAST) begin
            cx      <= '0;
            cy      <= (cy == Y_LAST) ? '0 : cy + 1'b1;
            bar_i   <= '0;
            bar_cnt <= '0;
        end else begin
            cx <= cx + 1'b1;
            // The last bar absorbs the remainder, so bar_i stops at 7
            if (bar_cnt == X_BAR_LAST && bar_i != 3'd7) begin
                bar_i   <= bar_i + 3'd1;
                bar_cnt <= '0;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
        end
    end

    // Frame-boundary values; the new frame's settings already apply at (0,0)
    always_comb begin
        at_start = (cx == '0) && (cy == '0);
        fc_next  = frame_cnt + 8'd1;
        bx_sum   = {1'b0, box_x} + BX_STEP;
        // box_x follows {frame_cnt,0} mod H_ACTIVE one step of 2 at a time
        if (fc_next == 8'd0) begin
            bx_next = '0;
        end else if (bx_sum >= BX_WRAP) begin
            bx_next = XW'(bx_sum - BX_WRAP);
        end else begin
            bx_next = bx_sum[XW-1:0];
        end
        mode_e = at_start ? mode : mode_q;
        bx_e   = at_start ? bx_next : box_x;
    end

    // Latch pattern select, count frames and advance the box at frame start
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            mode_q    <= '0;
            frame_cnt <= '0;
            box_x     <= '0;
        end else if (at_start) begin
            mode_q    <= mode;
            frame_cnt <= fc_next;
            box_x     <= bx_next;
        end
    end

    // Visibility, sync windows and pattern colour for the current raster position
    always_comb begin
        draw_c = (cx < X_ACT) && (cy < Y_ACT);
        hs_c   = (cx >= X_HS_ON) && (cx < X_HS_OFF);
        vs_c   = (cy >= Y_VS_ON) && (cy < Y_VS_OFF);
        cx_w   = {1'b0, cx};
        bx_w   = {1'b0, bx_e};
        in_box = (cx_w >= bx_w) && (cx_w < bx_w + BOX_SIZE) &&
                 (cy >= Y_BOX_TOP) && (cy < Y_BOX_BOT);
        // Low 8 bits of cx land in the top of the channel, zero-filled below
        ramp_w = {cx[7:0], {CW{1'b0}}};
        r_c    = '0;
        g_c    = '0;
        b_c    = '0;
        case (mode_e)
            3'd0: begin
                r_c = {CW{~bar_i[1]}};
                g_c = {CW{~bar_i[2]}};
                b_c = {CW{~bar_i[0]}};
            end
            3'd1: begin
                if (cx[4:0] == 5'd0 || cy[4:0] == 5'd0 || cx == X_EDGE || cy == Y_EDGE) begin
                    r_c = FULL;
                    g_c = FULL;
                    b_c = FULL;
                end
            end
            3'd2: begin
                r_c = ramp_w[CW+7:8];
                g_c = ramp_w[CW+7:8];
                b_c = ramp_w[CW+7:8];
            end
            3'd3: begin
                if (cx[5] ^ cy[5]) begin
                    r_c = FULL;
                    g_c = FULL;
                    b_c = FULL;
                end
            end
            3'd4: begin
                b_c = FULL;
                if (in_box) begin
                    r_c = FULL;
                    g_c = FULL;
                end
            end
            3'd5: begin
                r_c = FULL;
                g_c = FULL;
                b_c = FULL;
            end
            3'd6: begin
                r_c = FULL;
            end
            default: begin
                r_c = '0;
            end
        endcase
        // Blanking always forces black
        if (!draw_c) begin
            r_c = '0;
            g_c = '0;
            b_c = '0;
        end
    end

    // Output register stage: everything lags the counters by one clock
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            draw_area   <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else begin
            draw_area   <= draw_c;
            hsync       <= hs_c ? HS_POL : ~HS_POL;
            vsync       <= vs_c ? VS_POL : ~VS_POL;
            frame_start <= at_start;
            pix_x       <= cx;
            pix_y       <= cy;
            red         <= r_c;
            green       <= g_c;
            blue        <= b_c;
        end
    end

endmodule

// File: tb/tb_timing_pattern_gen.sv
// Bench for timing_pattern_gen on a reduced raster (68x40 visible, 84x46 total)
// so that many frames fit in a short run. A behavioural model predicts every
// output cycle; predictions are queued at the clock edge and compared at the
// following falling edge. Directed checks cover sync timing, mode latching,
// the moving box and a mid-frame reset.
module tb_timing_pattern_gen;

    localparam int HA  = 68;
    localparam int HFP = 4;
    localparam int HSY = 8;
    localparam int HBP = 4;
    localparam int VA  = 40;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int XW  = 8;
    localparam int YW  = 8;
    localparam int CW  = 8;
    localparam int OW  = 4 + XW + YW + 8 + 3 * CW;
    localparam int FRAME_BUDGET = HT * VT + 20;

    logic          pixclk;
    logic          rst;
    logic [2:0]    mode;
    logic          draw_area;
    logic          hsync;
    logic          vsync;
    logic          frame_start;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [7:0]    frame_cnt;
    logic [CW-1:0] red;
    logic [CW-1:0] green;
    logic [CW-1:0] blue;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] obs;
    logic [23:0]   rgb;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int m_cx;
    int m_cy;
    int m_mode;
    int m_fc;

    timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .XW(XW), .YW(YW)
    ) dut (
        .pixclk(pixclk),
        .rst(rst),
        .mode(mode),
        .draw_area(draw_area),
        .hsync(hsync),
        .vsync(vsync),
        .frame_start(frame_start),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .frame_cnt(frame_cnt),
        .red(red),
        .green(green),
        .blue(blue)
    );

    assign obs = {draw_area, hsync, vsync, frame_start, pix_x, pix_y, frame_cnt, red, green, blue};
    assign rgb = {red, green, blue};

    // Clock and watchdog
    initial begin
        pixclk = 1'b0;
        forever #5 pixclk = ~pixclk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for one raster position, written from the description
    function automatic logic [OW-1:0] model_out(int x, int y, int md, int fc, bit fs);
        logic d;
        logic hs;
        logic vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int i;
        int bx;
        d  = (x < HA) && (y < VA);
        hs = (x >= HA + HFP && x < HA + HFP + HSY) ? 1'b0 : 1'b1;
        vs = (y >= VA + VFP && y < VA + VFP + VSY) ? 1'b0 : 1'b1;
        r = 8'h00;
        g = 8'h00;
        b = 8'h00;
        if (d) begin
            case (md)
                0: begin
                    i = x / (HA / 8);
                    if (i > 7) i = 7;
                    r = ((i & 2) != 0) ? 8'h00 : 8'hFF;
                    g = ((i & 4) != 0) ? 8'h00 : 8'hFF;
                    b = ((i & 1) != 0) ? 8'h00 : 8'hFF;
                end
                1: if ((x % 32) == 0 || (y % 32) == 0 || x == HA - 1 || y == VA - 1) begin
                    r = 8'hFF; g = 8'hFF; b = 8'hFF;
                end
                2: begin
                    r = 8'(x % 256); g = 8'(x % 256); b = 8'(x % 256);
                end
                3: if (((x / 32) % 2) != ((y / 32) % 2)) begin
                    r = 8'hFF; g = 8'hFF; b = 8'hFF;
                end
                4: begin
                    bx = (2 * fc) % HA;
                    b = 8'hFF;
                    if (x >= bx && x < bx + 32 && y >= VA / 2 - 16 && y < VA / 2 + 16) begin
                        r = 8'hFF; g = 8'hFF;
                    end
                end
                5: begin
                    r = 8'hFF; g = 8'hFF; b = 8'hFF;
                end
                6: r = 8'hFF;
                default: r = 8'h00;
            endcase
        end
        return {d, hs, vs, fs, 8'(x), 8'(y), 8'(fc), r, g, b};
    endfunction

    // Model: predict the value each clock edge will put on the outputs
    always @(posedge pixclk) begin : model_p
        bit fs;
        if (rst) begin
            m_cx = 0;
            m_cy = 0;
            m_mode = 0;
            m_fc = 0;
            exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 24'd0});
        end else begin
            fs = (m_cx == 0 && m_cy == 0);
            if (fs) begin
                m_mode = int'(mode);
                m_fc = (m_fc + 1) % 256;
            end
            exp_q.push_back(model_out(m_cx, m_cy, m_mode, m_fc, fs));
            if (m_cx == HT - 1) begin
                m_cx = 0;
                m_cy = (m_cy == VT - 1) ? 0 : m_cy + 1;
            end else begin
                m_cx = m_cx + 1;
            end
        end
    end

    // Scoreboard: compare every cycle at the falling edge
    always @(negedge pixclk) begin
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'(exp_q.size()), 64'd1);
        end else begin
            check("pix", 64'(obs), 64'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(negedge pixclk);
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_start !== 1'b1 && n < FRAME_BUDGET);
        check("wait_fs", 64'(frame_start), 64'd1);
    endtask

    task automatic wait_pix(input int x, input int y);
        int n;
        n = 0;
        while (!(int'(pix_x) == x && int'(pix_y) == y) && n < FRAME_BUDGET) begin
            step();
            n++;
        end
        check("wait_xy", 64'({pix_x, pix_y}), 64'({8'(x), 8'(y)}));
    endtask

    initial begin
        int n;
        int m;
        int fc;
        int ml[5];
        ml = '{1, 2, 5, 6, 7};
        rst  = 1'b1;
        mode = 3'd0;

        // Reset state
        repeat (3) step();
        check("rst_hsync", 64'(hsync), 64'd1);
        check("rst_vsync", 64'(vsync), 64'd1);
        check("rst_draw", 64'(draw_area), 64'd0);
        check("rst_fs", 64'(frame_start), 64'd0);
        check("rst_fc", 64'(frame_cnt), 64'd0);
        check("rst_rgb", 64'(rgb), 64'd0);

        // First edge after release shows pixel (0,0) of frame 1
        #1 rst = 1'b0;
        step();
        check("first_fs", 64'(frame_start), 64'd1);
        check("first_da", 64'(draw_area), 64'd1);
        check("first_fc", 64'(frame_cnt), 64'd1);
        check("first_xy", 64'({pix_x, pix_y}), 64'd0);

        // hsync: start position, width, period
        n = 0;
        while (hsync !== 1'b0 && n < 2 * HT) begin step(); n++; end
        check("hs_start_x", 64'(pix_x), 64'(HA + HFP));
        n = 0;
        while (hsync === 1'b0 && n < 2 * HT) begin step(); n++; end
        check("hs_width", 64'(n), 64'(HSY));
        m = 0;
        while (hsync === 1'b1 && m < 2 * HT) begin step(); m++; end
        check("hs_period", 64'(n + m), 64'(HT));

        // vsync: start line, width in clocks
        n = 0;
        while (vsync !== 1'b0 && n < FRAME_BUDGET) begin step(); n++; end
        check("vs_start_y", 64'(pix_y), 64'(VA + VFP));
        check("vs_start_x", 64'(pix_x), 64'd0);
        n = 0;
        while (vsync === 1'b0 && n < FRAME_BUDGET) begin step(); n++; end
        check("vs_width", 64'(n), 64'(VSY * HT));

        // Frame length
        wait_fs();
        n = 0;
        do begin step(); n++; end while (frame_start !== 1'b1 && n < FRAME_BUDGET);
        check("frame_len", 64'(n), 64'(HT * VT));

        // Mode change mid-frame only takes effect at the next frame
        wait_pix(0, 10);
        #1 mode = 3'd3;
        wait_fs();
        check("chk_0_0", 64'(rgb), 64'h000000);
        wait_pix(32, 0);
        check("chk_32_0", 64'(rgb), 64'hFFFFFF);
        wait_pix(32, 32);
        check("chk_32_32", 64'(rgb), 64'h000000);

        // Moving box for three frames
        #1 mode = 3'd4;
        for (int k = 0; k < 3; k++) begin
            wait_fs();
            check("box_bg", 64'(rgb), 64'h0000FF);
            fc = int'(frame_cnt);
            wait_pix(2 * fc, VA / 2 - 16);
            check("box_left", 64'(rgb), 64'hFFFFFF);
            wait_pix(2 * fc + 31, VA / 2 + 15);
            check("box_corner", 64'(rgb), 64'hFFFFFF);
            step();
            check("box_right", 64'(rgb), 64'h0000FF);
            wait_pix(2 * fc, VA / 2 + 16);
            check("box_below", 64'(rgb), 64'h0000FF);
        end

        // Remaining patterns, each switched mid-frame
        for (int j = 0; j < 5; j++) begin
            wait_pix(HA / 2, VA / 2);
            #1 mode = 3'(ml[j]);
            wait_fs();
        end

        // Random pattern switches at random points
        for (int j = 0; j < 2; j++) begin
            repeat ($urandom_range(10, 3000)) step();
            #1 mode = 3'($urandom_range(0, 7));
            wait_fs();
        end

        // Reset in the middle of a frame
        wait_pix(30, 20);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("mrst_hsync", 64'(hsync), 64'd1);
            check("mrst_draw", 64'(draw_area), 64'd0);
            check("mrst_fs", 64'(frame_start), 64'd0);
            check("mrst_fc", 64'(frame_cnt), 64'd0);
            check("mrst_xy", 64'({pix_x, pix_y}), 64'd0);
        end
        #1 rst = 1'b0;
        step();
        check("rel_fs", 64'(frame_start), 64'd1);
        check("rel_fc", 64'(frame_cnt), 64'd1);
        check("rel_xy", 64'({pix_x, pix_y}), 64'd0);
        repeat (500) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
